id_scoreboard: RTL and testbench

- Register-hazard controller for the decode stage.
- Tracks in-flight writes per architectural register and stalls the decode/register-read stage when a source register is pending.
- Limits in-flight writes per register and sequences a drain handshake (fence/ecall style) that blocks issue until the pipeline holds no pending writes.
- Sits beside the decode control/immediate/register-file datapath; its o_issue qualifies the ID-to-EX pipeline register.

---
 rtl/id_scoreboard.sv | 140 ++++++++++++++
 tb/tb_id_scoreboard.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard for the decode stage: per-register pending-write counters,
// RAW/WAW stall generation and a drain handshake. Optional macro ID_SB_STALL_STATS_EN adds a stall-cycle counter.
module id_scoreboard #(
   parameter int NREGS = 32,
   parameter int CNT_W = 2,
   parameter int BYPASS = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   input  logic [4:0]       i_rs1,
   input  logic             i_rs1Used,
   input  logic [4:0]       i_rs2,
   input  logic             i_rs2Used,
   input  logic [4:0]       i_rd,
   input  logic             i_regWrite,
   input  logic             i_hold,
   input  logic             i_flush,
   input  logic             i_relValid,
   input  logic [4:0]       i_relReg,
   input  logic             i_drainReq,
   output logic             o_stall,
   output logic             o_issue,
   output logic             o_drainAck,
   output logic [NREGS-1:0] o_busy,
   output logic             o_err
`ifdef ID_SB_STALL_STATS_EN
   ,
   input  logic             i_statsClr,
   output logic [31:0]      o_stallCycles
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

   state_t state_reg, state_next;
   logic   err_reg;
   logic   hazard, waw_limit, issue, all_zero_next;

   logic [NREGS-1:0] eff_nz;
   logic [NREGS-1:0] full;
   logic [NREGS-1:0] zero_next;
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] rel_zero;

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            // x0 is hard-wired zero: never busy, never full, releases to it are dropped silently
            assign eff_nz[gi]    = 1'b0;
            assign full[gi]      = 1'b0;
            assign zero_next[gi] = 1'b1;
            assign busy[gi]      = 1'b0;
            assign rel_zero[gi]  = 1'b0;
         end else begin : g_cnt
            logic [CNT_W-1:0] cnt_reg, cnt_next, eff;
            logic rel_hit, byp_hit, inc, dec;

            assign rel_hit = i_relValid && (i_relReg == 5'(gi));
            assign byp_hit = rel_hit && (BYPASS != 0);
            assign eff     = cnt_reg - (byp_hit ? CNT_ONE : '0);
            assign inc     = issue && i_regWrite && (i_rd == 5'(gi));
            assign dec     = rel_hit && (cnt_reg != '0);

            always_comb begin
               cnt_next = cnt_reg;
               if (inc && !dec)
                  cnt_next = cnt_reg + CNT_ONE;
               else if (dec && !inc)
                  cnt_next = cnt_reg - CNT_ONE;
            end

            always_ff @(posedge i_clk or posedge i_reset) begin
               if (i_reset)
                  cnt_reg <= '0;
               else
                  cnt_reg <= cnt_next;
            end

            assign eff_nz[gi]    = (eff != '0);
            assign full[gi]      = (cnt_reg == CNT_MAX);
            assign zero_next[gi] = (cnt_next == '0);
            assign busy[gi]      = (cnt_reg != '0);
            assign rel_zero[gi]  = rel_hit && (cnt_reg == '0);
         end
      end
   endgenerate

   assign hazard        = (i_rs1Used && eff_nz[i_rs1]) || (i_rs2Used && eff_nz[i_rs2]);
   // The WAW limit looks at the registered count, so a same-cycle release does not lift it
   assign waw_limit     = i_regWrite && full[i_rd];
   assign o_stall       = i_valid && (hazard || waw_limit || i_hold || (state_reg != RUN));
   assign issue         = i_valid && !o_stall && !i_flush;
   assign o_issue       = issue;
   assign all_zero_next = &zero_next;
   assign o_busy        = busy;
   assign o_err         = err_reg;
   assign o_drainAck    = (state_reg == ACK);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (i_drainReq) state_next = DRAIN;
         DRAIN:   if (all_zero_next) state_next = ACK;
         ACK:     state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg <= RUN;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (|rel_zero)
            err_reg <= 1'b1;
      end
   end

`ifdef ID_SB_STALL_STATS_EN
   logic [31:0] stall_cycles_reg;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         stall_cycles_reg <= '0;
      else if (i_statsClr)
         stall_cycles_reg <= '0;
      else if (i_valid && (hazard || waw_limit) && (stall_cycles_reg != 32'hFFFF_FFFF))
         stall_cycles_reg <= stall_cycles_reg + 32'd1;
   end

   assign o_stallCycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed steps plus random traffic compared
// against a behavioural model of pending-write counts and the drain handshake.
module tb_id_scoreboard;

   localparam int BYPASS = 1;
   localparam int CMAX = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 0, rs1_used = 0, rs2_used = 0, reg_write = 0;
   logic        hold = 0, flush = 0, rel = 0, drain_req = 0;
   logic [4:0]  rs1 = 0, rs2 = 0, rd = 0, rel_reg = 0;
   logic        stall, issue, drain_ack, err;
   logic [31:0] busy;

   int passed = 0;
   int total = 0;

   // behavioural model: pending writes per register, sticky error, drain phase 0=run 1=drain 2=ack
   int m_cnt[32];
   bit m_err;
   int m_phase;
   bit exp_stall, exp_issue;

   id_scoreboard #(.NREGS(32), .CNT_W(2), .BYPASS(BYPASS)) dut (
      .i_clk(clk), .i_reset(rst), .i_valid(valid),
      .i_rs1(rs1), .i_rs1Used(rs1_used), .i_rs2(rs2), .i_rs2Used(rs2_used),
      .i_rd(rd), .i_regWrite(reg_write), .i_hold(hold), .i_flush(flush),
      .i_relValid(rel), .i_relReg(rel_reg), .i_drainReq(drain_req),
      .o_stall(stall), .o_issue(issue), .o_drainAck(drain_ack),
      .o_busy(busy), .o_err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 0;
      m_phase = 0;
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] b = '0;
      for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
      return b;
   endfunction

   function automatic bit src_pending(input logic [4:0] r);
      int e;
      if (r == 0) return 0;
      e = m_cnt[r] - ((BYPASS != 0 && rel && rel_reg == r) ? 1 : 0);
      return e != 0;
   endfunction

   task automatic idle();
      valid = 0; rs1 = 0; rs1_used = 0; rs2 = 0; rs2_used = 0; rd = 0; reg_write = 0;
      hold = 0; flush = 0; rel = 0; rel_reg = 0; drain_req = 0;
   endtask

   // inputs were set just after a rising edge; check at the falling edge
   task automatic settle();
      bit hz, waw;
      #4;
      hz = (rs1_used && src_pending(rs1)) || (rs2_used && src_pending(rs2));
      waw = reg_write && rd != 0 && m_cnt[rd] == CMAX;
      exp_stall = valid && (hz || waw || hold || m_phase != 0);
      exp_issue = valid && !exp_stall && !flush;
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
      chk("issue", {31'b0, issue}, {31'b0, exp_issue});
      chk("busy", busy, model_busy());
      chk("drain_ack", {31'b0, drain_ack}, {31'b0, m_phase == 2});
      chk("err", {31'b0, err}, {31'b0, m_err});
   endtask

   task automatic tick();
      int nc[32];
      int sum = 0;
      @(posedge clk);
      for (int r = 0; r < 32; r++) nc[r] = m_cnt[r];
      if (exp_issue && reg_write && rd != 0) nc[rd]++;
      if (rel && rel_reg != 0) begin
         if (m_cnt[rel_reg] > 0) nc[rel_reg]--;
         else m_err = 1;
      end
      for (int r = 0; r < 32; r++) begin
         m_cnt[r] = nc[r];
         sum += nc[r];
      end
      case (m_phase)
         0: if (drain_req) m_phase = 1;
         1: if (sum == 0) m_phase = 2;
         default: m_phase = 0;
      endcase
      #1;
   endtask

   task automatic cycle();
      settle();
      tick();
   endtask

   initial begin
      int sum;
      int pick;
      model_reset();
      idle();
      #12 rst = 0;
      @(posedge clk); #1;
      chk("reset_busy", busy, 32'h0);
      chk("reset_err", {31'b0, err}, 32'h0);
      chk("reset_ack", {31'b0, drain_ack}, 32'h0);

      // RAW: writer to x5 then reader stalls until x5 is released
      valid = 1; rd = 5; reg_write = 1; cycle();
      idle(); valid = 1; rs1 = 5; rs1_used = 1;
      settle(); chk("raw_stall", {31'b0, stall}, 32'h1); chk("raw_busy5", {31'b0, busy[5]}, 32'h1); tick();
      rel = 1; rel_reg = 5;
      settle(); chk("raw_bypass_issue", {31'b0, issue}, 32'h1); tick();

      // x0 never tracked
      idle();
      for (int i = 0; i < 10; i++) begin
         valid = 1; rd = 0; reg_write = 1; rs1 = 0; rs2 = 0; rs1_used = 1; rs2_used = 1;
         cycle();
      end
      settle(); chk("x0_busy", busy, 32'h0); chk("x0_stall", {31'b0, stall}, 32'h0); tick();

      // WAW saturation on x7
      idle(); valid = 1; rd = 7; reg_write = 1;
      for (int i = 0; i < 3; i++) cycle();
      settle(); chk("waw_full_stall", {31'b0, stall}, 32'h1); tick();
      rel = 1; rel_reg = 7;
      settle(); chk("waw_rel_no_lift", {31'b0, stall}, 32'h1); tick();
      settle(); chk("waw_issue_same_cycle_rel", {31'b0, issue}, 32'h1); tick();
      idle(); rel = 1; rel_reg = 7;
      for (int i = 0; i < 3; i++) cycle();

      // flush squashes the writer
      idle(); valid = 1; flush = 1; rd = 9; reg_write = 1;
      settle(); chk("flush_issue", {31'b0, issue}, 32'h0); tick();
      idle(); cycle();

      // drain with x3 and x4 pending
      valid = 1; reg_write = 1; rd = 3; cycle();
      rd = 4; cycle();
      idle(); drain_req = 1; cycle();
      idle(); valid = 1; rs1 = 1; rs1_used = 1;
      settle(); chk("drain_block", {31'b0, issue}, 32'h0); tick();
      rel = 1; rel_reg = 3; cycle();
      rel_reg = 4;
      settle(); chk("drain_block2", {31'b0, issue}, 32'h0); tick();
      rel = 0;
      settle(); chk("drain_ack_pulse", {31'b0, drain_ack}, 32'h1); tick();
      settle(); chk("drain_resume", {31'b0, issue}, 32'h1); tick();

      // random traffic on x0..x7
      for (int n = 0; n < 500; n++) begin
         idle();
         valid = ($urandom_range(0, 3) != 0);
         rs1 = 5'($urandom_range(0, 7)); rs1_used = $urandom_range(0, 1);
         rs2 = 5'($urandom_range(0, 7)); rs2_used = $urandom_range(0, 1);
         rd = 5'($urandom_range(0, 7)); reg_write = $urandom_range(0, 1);
         hold = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 9) == 0);
         drain_req = ($urandom_range(0, 29) == 0);
         pick = $urandom_range(0, 7);
         if (m_cnt[pick] > 0 && $urandom_range(0, 1) == 1) begin
            rel = 1; rel_reg = 5'(pick);
         end
         cycle();
      end

      // retire everything and let any drain complete
      for (int n = 0; n < 200; n++) begin
         idle();
         sum = 0;
         for (int r = 1; r < 32; r++) begin
            sum += m_cnt[r];
            if (!rel && m_cnt[r] > 0) begin rel = 1; rel_reg = 5'(r); end
         end
         if (sum == 0 && m_phase == 0) break;
         cycle();
      end
      idle();
      settle(); chk("drained_busy", busy, 32'h0); tick();

      // release at zero count sets a sticky error
      rel = 1; rel_reg = 9; cycle();
      idle();
      settle(); chk("err_set", {31'b0, err}, 32'h1); tick();
      cycle();
      settle(); chk("err_sticky", {31'b0, err}, 32'h1); tick();

      // async reset in the middle of a drain with x6 pending twice
      valid = 1; reg_write = 1; rd = 6; cycle(); cycle();
      idle(); drain_req = 1; cycle();
      idle(); cycle();
      #1 rst = 1;
      #1;
      model_reset();
      chk("rst_busy", busy, 32'h0);
      chk("rst_ack", {31'b0, drain_ack}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      @(posedge clk); #1 rst = 0;
      valid = 1; rs1 = 6; rs1_used = 1;
      settle(); chk("post_rst_issue", {31'b0, issue}, 32'h1); tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
